// File: rtl/packet_parser.sv
// -----------------------------------------------------------------------------
// packet_parser
// Validates framed command packets arriving from a UART receiver:
//   HEADER, channel id, PAYLOAD_BYTES payload bytes (big-endian), checksum.
// The checksum is the 8-bit sum of the channel id and all payload bytes.
// Each accepted payload is stored in a per-channel register bank and announced
// with a one-cycle strobe. Discarded packets (errored byte, bad channel, bad
// checksum, inter-byte timeout) are counted in a saturating 8-bit counter.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_rx_stb              one-cycle strobe, i_rx_data holds a byte
//   i_rx_data [7:0]       received byte
//   i_rx_err              receiver error flag, qualified by i_rx_stb
//   o_valid               one-cycle pulse per accepted packet
//   o_chan [CW-1:0]       channel of the last accepted packet
//   o_payload [DATA_W-1:0] payload of the last accepted packet
//   o_regs                per-channel latest payload, slot k at [k*DATA_W +: DATA_W]
//   o_err_cnt [7:0]       saturating count of discarded packets
//   o_busy                high while the parser is inside a packet
// -----------------------------------------------------------------------------
module packet_parser #(
    parameter logic [7:0] HEADER         = 8'hF5,
    parameter int         PAYLOAD_BYTES  = 2,
    parameter int         CHANNELS       = 2,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter int         RESET_VALUE    = 50,
    localparam int        DATA_W         = 8 * PAYLOAD_BYTES,
    localparam int        CW             = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_rx_stb,
    input  logic [7:0]                   i_rx_data,
    input  logic                         i_rx_err,
    output logic                         o_valid,
    output logic [CW-1:0]                o_chan,
    output logic [DATA_W-1:0]            o_payload,
    output logic [CHANNELS*DATA_W-1:0]   o_regs,
    output logic [7:0]                   o_err_cnt,
    output logic                         o_busy
);

    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHAN    = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHECK   = 2'd3
    } state_t;

    state_t                      state_r, state_nxt;
    logic [CW-1:0]               chan_r, chan_nxt;
    logic [7:0]                  sum_r, sum_nxt;
    logic [2:0]                  idx_r, idx_nxt;
    logic [DATA_W-1:0]           payload_r, payload_nxt;
    logic [TW-1:0]               tcnt_r, tcnt_nxt;
    logic                        accept_s, abort_s;
    logic                        good_s, timeout_s;

    logic                        valid_r;
    logic [CW-1:0]               out_chan_r;
    logic [DATA_W-1:0]           out_payload_r;
    logic [CHANNELS*DATA_W-1:0]  regs_r;
    logic [7:0]                  err_cnt_r;
    logic                        busy_r;

    assign good_s = i_rx_stb & ~i_rx_err;

    // A strobe in the expiry cycle takes precedence, so the timeout only fires
    // on strobe-free cycles.
    assign timeout_s = (TIMEOUT_CYCLES != 0) && (state_r != ST_IDLE) && !i_rx_stb
                       && (tcnt_r == TW'(TIMEOUT_CYCLES));

    // Next-state, datapath and accept/abort decode.
    always_comb begin
        state_nxt   = state_r;
        chan_nxt    = chan_r;
        sum_nxt     = sum_r;
        idx_nxt     = idx_r;
        payload_nxt = payload_r;
        accept_s    = 1'b0;
        abort_s     = 1'b0;

        if ((state_r == ST_IDLE) || i_rx_stb || (TIMEOUT_CYCLES == 0)) begin
            tcnt_nxt = '0;
        end else begin
            tcnt_nxt = tcnt_r + TW'(1);
        end

        case (state_r)
            ST_IDLE: begin
                if (good_s && (i_rx_data == HEADER)) begin
                    state_nxt = ST_CHAN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CHAN: begin
                if (good_s) begin
                    if (i_rx_data < 8'(CHANNELS)) begin
                        chan_nxt  = i_rx_data[CW-1:0];
                        sum_nxt   = i_rx_data;
                        idx_nxt   = 3'd0;
                        state_nxt = ST_PAYLOAD;
                    end else begin
                        abort_s   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else if (i_rx_stb || timeout_s) begin
                    abort_s   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_CHAN;
                end
            end
            ST_PAYLOAD: begin
                if (good_s) begin
                    // Big-endian: earlier bytes shift toward the MSB.
                    payload_nxt = (payload_r << 4'd8) | DATA_W'(i_rx_data);
                    sum_nxt     = sum_r + i_rx_data;
                    idx_nxt     = idx_r + 3'd1;
                    if (idx_r == 3'(PAYLOAD_BYTES - 1)) begin
                        state_nxt = ST_CHECK;
                    end else begin
                        state_nxt = ST_PAYLOAD;
                    end
                end else if (i_rx_stb || timeout_s) begin
                    abort_s   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_PAYLOAD;
                end
            end
            ST_CHECK: begin
                if (good_s) begin
                    if (i_rx_data == sum_r) begin
                        accept_s = 1'b1;
                    end else begin
                        abort_s = 1'b1;
                    end
                    state_nxt = ST_IDLE;
                end else if (i_rx_stb || timeout_s) begin
                    abort_s   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_CHECK;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Parser state and packet-assembly registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            chan_r    <= '0;
            sum_r     <= 8'd0;
            idx_r     <= 3'd0;
            payload_r <= '0;
            tcnt_r    <= '0;
        end else begin
            state_r   <= state_nxt;
            chan_r    <= chan_nxt;
            sum_r     <= sum_nxt;
            idx_r     <= idx_nxt;
            payload_r <= payload_nxt;
            tcnt_r    <= tcnt_nxt;
        end
    end

    // Registered outputs: accept strobe, result capture, register bank, error count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_r       <= 1'b0;
            out_chan_r    <= '0;
            out_payload_r <= '0;
            regs_r        <= {CHANNELS{DATA_W'(RESET_VALUE)}};
            err_cnt_r     <= 8'd0;
            busy_r        <= 1'b0;
        end else begin
            valid_r <= accept_s;
            busy_r  <= (state_nxt != ST_IDLE);
            if (accept_s) begin
                out_chan_r                      <= chan_r;
                out_payload_r                   <= payload_r;
                regs_r[chan_r*DATA_W +: DATA_W] <= payload_r;
            end
            if (abort_s && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
        end
    end

    assign o_valid   = valid_r;
    assign o_chan    = out_chan_r;
    assign o_payload = out_payload_r;
    assign o_regs    = regs_r;
    assign o_err_cnt = err_cnt_r;
    assign o_busy    = busy_r;

endmodule

// File: tb/tb_packet_parser.sv
// -----------------------------------------------------------------------------
// tb_packet_parser
// Directed self-checking bench for packet_parser with default parameters except
// TIMEOUT_CYCLES = 20. Inputs change on the falling edge; outputs are checked
// on the falling edge following the capturing rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_packet_parser;

    localparam int T = 20;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_rx_stb = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_err = 1'b0;
    logic        o_valid;
    logic [0:0]  o_chan;
    logic [15:0] o_payload;
    logic [31:0] o_regs;
    logic [7:0]  o_err_cnt;
    logic        o_busy;

    int total = 0;
    int bad   = 0;

    packet_parser #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_rx_stb  (i_rx_stb),
        .i_rx_data (i_rx_data),
        .i_rx_err  (i_rx_err),
        .o_valid   (o_valid),
        .o_chan    (o_chan),
        .o_payload (o_payload),
        .o_regs    (o_regs),
        .o_err_cnt (o_err_cnt),
        .o_busy    (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Drives one strobed byte for one cycle; called and returns at a falling edge.
    task automatic send(input logic [7:0] b, input logic e);
        i_rx_stb  = 1'b1;
        i_rx_data = b;
        i_rx_err  = e;
        @(negedge i_clk);
        i_rx_stb  = 1'b0;
        i_rx_err  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge i_clk);
    endtask

    task automatic test_reset();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", o_valid); end
        total++; if (o_chan !== 1'b0) begin bad++; $display("FAIL reset_chan got=%0h exp=0", o_chan); end
        total++; if (o_payload !== 16'h0000) begin bad++; $display("FAIL reset_payload got=%0h exp=0", o_payload); end
        total++; if (o_regs !== {16'd50, 16'd50}) begin bad++; $display("FAIL reset_regs got=%0h exp=%0h", o_regs, {16'd50, 16'd50}); end
        total++; if (o_err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err got=%0d exp=0", o_err_cnt); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", o_busy); end
    endtask

    task automatic test_accept();
        send(8'h33, 1'b0);
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL junk_busy got=%0h exp=0", o_busy); end
        send(8'hF5, 1'b0);
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL hdr_busy got=%0h exp=1", o_busy); end
        send(8'h01, 1'b0);
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL early_valid got=%0h exp=0", o_valid); end
        send(8'h47, 1'b0);
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL acc_valid got=%0h exp=1", o_valid); end
        total++; if (o_chan !== 1'b1) begin bad++; $display("FAIL acc_chan got=%0h exp=1", o_chan); end
        total++; if (o_payload !== 16'h1234) begin bad++; $display("FAIL acc_payload got=%0h exp=1234", o_payload); end
        total++; if (o_regs !== {16'h1234, 16'd50}) begin bad++; $display("FAIL acc_regs got=%0h exp=%0h", o_regs, {16'h1234, 16'd50}); end
        total++; if (o_err_cnt !== 8'd0) begin bad++; $display("FAIL acc_err got=%0d exp=0", o_err_cnt); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL acc_busy got=%0h exp=0", o_busy); end
        idle(1);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL valid_pulse got=%0h exp=0", o_valid); end
        total++; if (o_payload !== 16'h1234) begin bad++; $display("FAIL payload_hold got=%0h exp=1234", o_payload); end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] pk [5] = '{8'hF5, 8'h00, 8'hAB, 8'hCD, 8'h00};
        for (int i = 0; i < 5; i++) send(pk[i], 1'b0);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL cks_valid got=%0h exp=0", o_valid); end
        total++; if (o_err_cnt !== 8'd1) begin bad++; $display("FAIL cks_err got=%0d exp=1", o_err_cnt); end
        total++; if (o_regs !== {16'h1234, 16'd50}) begin bad++; $display("FAIL cks_regs got=%0h exp=%0h", o_regs, {16'h1234, 16'd50}); end
        pk[4] = 8'h78;
        for (int i = 0; i < 5; i++) send(pk[i], 1'b0);
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL cks_ok_valid got=%0h exp=1", o_valid); end
        total++; if (o_chan !== 1'b0) begin bad++; $display("FAIL cks_ok_chan got=%0h exp=0", o_chan); end
        total++; if (o_regs !== {16'h1234, 16'hABCD}) begin bad++; $display("FAIL cks_ok_regs got=%0h exp=%0h", o_regs, {16'h1234, 16'hABCD}); end
        idle(1);
    endtask

    task automatic test_bad_channel();
        logic [7:0] tail [4] = '{8'h01, 8'h12, 8'h34, 8'h47};
        send(8'hF5, 1'b0);
        send(8'h02, 1'b0);
        total++; if (o_err_cnt !== 8'd2) begin bad++; $display("FAIL chan_err got=%0d exp=2", o_err_cnt); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL chan_busy got=%0h exp=0", o_busy); end
        for (int i = 0; i < 4; i++) begin
            send(tail[i], 1'b0);
            total++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL chan_ignored byte=%0d valid=%0h busy=%0h exp=0/0", i, o_valid, o_busy); end
        end
        total++; if (o_err_cnt !== 8'd2) begin bad++; $display("FAIL chan_err_hold got=%0d exp=2", o_err_cnt); end
    endtask

    task automatic test_timeout();
        send(8'hF5, 1'b0); send(8'h01, 1'b0); send(8'h12, 1'b0);
        idle(T);
        total++; if (o_busy !== 1'b1 || o_err_cnt !== 8'd2) begin bad++; $display("FAIL to_early busy=%0h err=%0d exp=1/2", o_busy, o_err_cnt); end
        idle(1);
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL to_busy got=%0h exp=0", o_busy); end
        total++; if (o_err_cnt !== 8'd3) begin bad++; $display("FAIL to_err got=%0d exp=3", o_err_cnt); end
        // Strobe lands on the exact expiry cycle and must win.
        send(8'hF5, 1'b0); send(8'h01, 1'b0); send(8'h56, 1'b0);
        idle(T);
        send(8'h78, 1'b0);
        send(8'hCF, 1'b0);
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL to_edge_valid got=%0h exp=1", o_valid); end
        total++; if (o_payload !== 16'h5678) begin bad++; $display("FAIL to_edge_payload got=%0h exp=5678", o_payload); end
        total++; if (o_err_cnt !== 8'd3) begin bad++; $display("FAIL to_edge_err got=%0d exp=3", o_err_cnt); end
        idle(1);
    endtask

    task automatic test_rx_err();
        send(8'hF5, 1'b0); send(8'h01, 1'b0); send(8'hF5, 1'b1);
        total++; if (o_err_cnt !== 8'd4 || o_busy !== 1'b0) begin bad++; $display("FAIL rxerr err=%0d busy=%0h exp=4/0", o_err_cnt, o_busy); end
        send(8'h34, 1'b0); send(8'h2A, 1'b0);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rxerr_valid got=%0h exp=0", o_valid); end
        send(8'hF5, 1'b0); send(8'h01, 1'b0); send(8'hF5, 1'b0); send(8'h34, 1'b0); send(8'h2A, 1'b0);
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL hdr_data_valid got=%0h exp=1", o_valid); end
        total++; if (o_payload !== 16'hF534) begin bad++; $display("FAIL hdr_data_payload got=%0h exp=f534", o_payload); end
        total++; if (o_regs !== {16'hF534, 16'hABCD}) begin bad++; $display("FAIL hdr_data_regs got=%0h exp=%0h", o_regs, {16'hF534, 16'hABCD}); end
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] a [5] = '{8'hF5, 8'h00, 8'h11, 8'h22, 8'h33};
        logic [7:0] b [5] = '{8'hF5, 8'h01, 8'h01, 8'h02, 8'h04};
        for (int i = 0; i < 5; i++) send(a[i], 1'b0);
        total++; if (o_valid !== 1'b1 || o_payload !== 16'h1122) begin bad++; $display("FAIL b2b_first valid=%0h payload=%0h exp=1/1122", o_valid, o_payload); end
        for (int i = 0; i < 5; i++) send(b[i], 1'b0);
        total++; if (o_valid !== 1'b1 || o_chan !== 1'b1 || o_payload !== 16'h0102) begin bad++; $display("FAIL b2b_second valid=%0h chan=%0h payload=%0h exp=1/1/0102", o_valid, o_chan, o_payload); end
        total++; if (o_regs !== {16'h0102, 16'h1122} || o_err_cnt !== 8'd4) begin bad++; $display("FAIL b2b_regs regs=%0h err=%0d exp=%0h/4", o_regs, o_err_cnt, {16'h0102, 16'h1122}); end
        idle(1);
    endtask

    task automatic test_reset_mid();
        send(8'hF5, 1'b0); send(8'h01, 1'b0); send(8'h12, 1'b0);
        i_rst = 1'b1;
        #1;
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", o_busy); end
        total++; if (o_regs !== {16'd50, 16'd50}) begin bad++; $display("FAIL rst_regs got=%0h exp=%0h", o_regs, {16'd50, 16'd50}); end
        total++; if (o_err_cnt !== 8'd0 || o_payload !== 16'h0000 || o_chan !== 1'b0) begin bad++; $display("FAIL rst_outs err=%0d payload=%0h chan=%0h exp=0/0/0", o_err_cnt, o_payload, o_chan); end
        @(negedge i_clk);
        i_rst = 1'b0;
        send(8'h34, 1'b0);
        send(8'h47, 1'b0);
        total++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL rst_tail valid=%0h busy=%0h exp=0/0", o_valid, o_busy); end
        idle(1);
        total++; if (o_valid !== 1'b0 || o_err_cnt !== 8'd0) begin bad++; $display("FAIL rst_tail2 valid=%0h err=%0d exp=0/0", o_valid, o_err_cnt); end
    endtask

    initial begin
        idle(2);
        test_reset();
        i_rst = 1'b0;
        idle(1);
        test_accept();
        test_bad_checksum();
        test_bad_channel();
        test_timeout();
        test_rx_err();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
